// File: rtl/sram_like_arbiter_if.sv
// rtl/sram_like_arbiter_if.sv - master-side and slave-side sram-like bus bundle for sram_like_arbiter
//
// Purpose: groups the per-channel request bus and the single merged slave bus.
// Signals:
//   m_req/m_wr [NCH], m_size [2*NCH], m_addr [ADDR_W*NCH], m_wdata [DATA_W*NCH]  (masters -> arbiter)
//   m_addr_ok/m_data_ok [NCH], m_rdata [DATA_W]                                  (arbiter -> masters)
//   s_req, s_wr, s_size [2], s_addr [ADDR_W], s_wdata [DATA_W]                   (arbiter -> slave)
//   s_addr_ok, s_data_ok, s_rdata [DATA_W]                                        (slave -> arbiter)
// Modports: arb (the arbiter), master (the requesting channels), slave (the memory).
interface sram_like_arbiter_if #(
  parameter int NCH    = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [NCH-1:0]        m_req;
  logic [NCH-1:0]        m_wr;
  logic [2*NCH-1:0]      m_size;
  logic [ADDR_W*NCH-1:0] m_addr;
  logic [DATA_W*NCH-1:0] m_wdata;
  logic [NCH-1:0]        m_addr_ok;
  logic [NCH-1:0]        m_data_ok;
  logic [DATA_W-1:0]     m_rdata;

  logic                  s_req;
  logic                  s_wr;
  logic [1:0]            s_size;
  logic [ADDR_W-1:0]     s_addr;
  logic [DATA_W-1:0]     s_wdata;
  logic                  s_addr_ok;
  logic                  s_data_ok;
  logic [DATA_W-1:0]     s_rdata;

  modport arb (
    input  m_req, m_wr, m_size, m_addr, m_wdata,
    output m_addr_ok, m_data_ok, m_rdata,
    output s_req, s_wr, s_size, s_addr, s_wdata,
    input  s_addr_ok, s_data_ok, s_rdata
  );

  modport master (
    output m_req, m_wr, m_size, m_addr, m_wdata,
    input  m_addr_ok, m_data_ok, m_rdata
  );

  modport slave (
    input  s_req, s_wr, s_size, s_addr, s_wdata,
    output s_addr_ok, s_data_ok, s_rdata
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - N-channel round-robin arbiter onto one sram-like bus, one transaction in flight
//
// Purpose: merges NCH sram-like requesters (channel 0 = fetch) onto a single
// variable-latency slave using addr_ok/data_ok handshakes. Only one
// transaction is outstanding: IDLE picks a channel, ADDR presents it to the
// slave until addr_ok (or the master withdraws), DATA waits for data_ok.
// Ports:
//   clk     - clock, all state on rising edge
//   resetn  - asynchronous active-low reset
//   bus     - sram_like_arbiter_if.arb: per-channel master bus and merged slave bus
// Build option: define ARB_FIXED_PRIO_EN to replace round-robin with
// lowest-index-wins priority (the last-grant register then does not exist).
module sram_like_arbiter #(
  parameter int NCH    = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  sram_like_arbiter_if.arb bus
);

  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [GW-1:0]     r_grant;
  logic [GW-1:0]     w_pick;
  logic [GW-1:0]     w_idx;
  logic [DATA_W-1:0] r_rdata;
  logic [NCH-1:0]    w_grant_oh;
  logic              w_any;
  logic              w_greq;
  logic              w_take_addr;
  logic              w_take_data;
`ifndef ARB_FIXED_PRIO_EN
  logic [GW-1:0]     r_last;
`endif

  assign w_any       = |bus.m_req;
  assign w_greq      = bus.m_req[r_grant];
  assign w_grant_oh  = NCH'(1) << r_grant;
  assign w_take_addr = (r_state == S_ADDR) && w_greq && bus.s_addr_ok;
  assign w_take_data = (r_state == S_DATA) && bus.s_data_ok;

  // Channel selection. The loops run from lowest to highest priority so the
  // last hit is the winner.
  always_comb begin
    w_pick = '0;
    w_idx  = '0;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = NCH - 1; i >= 0; i--) begin
      w_idx = GW'(i);
      if (bus.m_req[w_idx]) w_pick = w_idx;
    end
`else
    // k = NCH revisits r_last itself (lowest priority); k = 1 is the channel
    // right after it (highest priority), wrapping NCH-1 -> 0.
    for (int k = NCH; k >= 1; k--) begin
      w_idx = GW'((int'(r_last) + k) % NCH);
      if (bus.m_req[w_idx]) w_pick = w_idx;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Grant, last-grant and read-data mirror registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_grant <= '0;
      r_rdata <= '0;
`ifndef ARB_FIXED_PRIO_EN
      r_last  <= GW'(NCH - 1);
`endif
    end else begin
      if ((r_state == S_IDLE) && w_any) r_grant <= w_pick;
`ifndef ARB_FIXED_PRIO_EN
      // A cancelled request never reaches here, so it does not move the pointer.
      if (w_take_addr) r_last <= r_grant;
`endif
      if (w_take_data) r_rdata <= bus.s_rdata;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_any) w_next = S_ADDR;
      S_ADDR: begin
        // A withdrawn request wins over a coincident addr_ok: s_req was already
        // low, so the slave cannot legitimately have accepted it.
        if (!w_greq)             w_next = S_IDLE;
        else if (bus.s_addr_ok)  w_next = S_DATA;
      end
      S_DATA: if (bus.s_data_ok) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic. Slave fields are zero outside ADDR so an idle bus is quiet.
  always_comb begin
    bus.s_req     = 1'b0;
    bus.s_wr      = 1'b0;
    bus.s_size    = '0;
    bus.s_addr    = '0;
    bus.s_wdata   = '0;
    bus.m_addr_ok = '0;
    bus.m_data_ok = '0;
    bus.m_rdata   = r_rdata;
    case (r_state)
      S_ADDR: begin
        bus.s_req = w_greq;
        for (int i = 0; i < NCH; i++) begin
          if (r_grant == GW'(i)) begin
            bus.s_wr    = bus.m_wr[i];
            bus.s_size  = bus.m_size[2*i +: 2];
            bus.s_addr  = bus.m_addr[i*ADDR_W +: ADDR_W];
            bus.s_wdata = bus.m_wdata[i*DATA_W +: DATA_W];
          end
        end
        if (w_take_addr) bus.m_addr_ok = w_grant_oh;
      end
      S_DATA: begin
        if (bus.s_data_ok) begin
          bus.m_data_ok = w_grant_oh;
          bus.m_rdata   = bus.s_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb/tb_sram_like_arbiter.sv - self-checking bench for sram_like_arbiter (NCH=2)
module tb_sram_like_arbiter;
  localparam int NCH    = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic clk;
  logic resetn;

  sram_like_arbiter_if #(.NCH(NCH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  sram_like_arbiter #(.NCH(NCH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.arb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  wr;
    logic [3:0]  size;
    logic [31:0] a0, a1, w0, w1;
    logic        sao, sdo;
    logic [31:0] srd;
    logic        e_sreq, e_swr;
    logic [1:0]  e_ssize;
    logic [31:0] e_saddr, e_swdata;
    logic [1:0]  e_aok, e_dok;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tv[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(logic [1:0] req, logic sao, logic sdo, logic [31:0] srd);
    @(negedge clk);
    bus.m_req     = req;
    bus.s_addr_ok = sao;
    bus.s_data_ok = sdo;
    bus.s_rdata   = srd;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn        = 1'b0;
    bus.m_req     = '0;
    bus.s_addr_ok = 1'b0;
    bus.s_data_ok = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  // Reference arbitration rule: first requester after the previous grant,
  // or lowest index when fixed priority is built.
  function automatic int pick(int last, logic [NCH-1:0] r);
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < NCH; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= NCH; k++) if (r[(last + k) % NCH]) return (last + k) % NCH;
`endif
    return 0;
  endfunction

  // Round-robin sequence state.
  int   got[4];
  int   exp_rr[4];
  int   ndok;
  int   ngrant;
  logic dph;

  // Random-phase model state.
  logic [NCH-1:0] mreq, prev_aok;
  logic [31:0]    maddr[NCH];
  logic [31:0]    mwd[NCH];
  logic           mwr[NCH];
  logic [1:0]     msz[NCH];
  int             ph;       // 0 waiting for a grant decision, 1 address phase, 2 data phase
  int             eg;
  int             lastg;
  int             scnt;
  int             ntx;
  logic           sbusy;
  logic [31:0]    mrd;

  initial begin
    // Single read on ch0, then spurious slave pulses while idle, then a ch1 byte write.
    tv.push_back('{2'b01,2'b00,4'b0010,32'hBFC00000,32'h13,32'h0,32'hAB,1'b0,1'b0,32'h0,       1'b0,1'b0,2'd0,32'h0,       32'h0, 2'b00,2'b00,32'h0});
    tv.push_back('{2'b01,2'b00,4'b0010,32'hBFC00000,32'h13,32'h0,32'hAB,1'b0,1'b0,32'h0,       1'b1,1'b0,2'd2,32'hBFC00000,32'h0, 2'b00,2'b00,32'h0});
    tv.push_back('{2'b01,2'b00,4'b0010,32'hBFC00000,32'h13,32'h0,32'hAB,1'b1,1'b0,32'h0,       1'b1,1'b0,2'd2,32'hBFC00000,32'h0, 2'b01,2'b00,32'h0});
    tv.push_back('{2'b00,2'b00,4'b0010,32'hBFC00000,32'h13,32'h0,32'hAB,1'b0,1'b0,32'h0,       1'b0,1'b0,2'd0,32'h0,       32'h0, 2'b00,2'b00,32'h0});
    tv.push_back('{2'b00,2'b00,4'b0010,32'hBFC00000,32'h13,32'h0,32'hAB,1'b0,1'b1,32'h3C080001,1'b0,1'b0,2'd0,32'h0,       32'h0, 2'b00,2'b01,32'h3C080001});
    tv.push_back('{2'b00,2'b00,4'b0010,32'hBFC00000,32'h13,32'h0,32'hAB,1'b1,1'b1,32'hDEAD,    1'b0,1'b0,2'd0,32'h0,       32'h0, 2'b00,2'b00,32'h3C080001});
    tv.push_back('{2'b10,2'b10,4'b0010,32'hBFC00000,32'h13,32'h0,32'hAB,1'b0,1'b0,32'h0,       1'b0,1'b0,2'd0,32'h0,       32'h0, 2'b00,2'b00,32'h3C080001});
    tv.push_back('{2'b10,2'b10,4'b0010,32'hBFC00000,32'h13,32'h0,32'hAB,1'b0,1'b0,32'h0,       1'b1,1'b1,2'd0,32'h13,      32'hAB,2'b00,2'b00,32'h3C080001});
    tv.push_back('{2'b10,2'b10,4'b0010,32'hBFC00000,32'h13,32'h0,32'hAB,1'b1,1'b0,32'h0,       1'b1,1'b1,2'd0,32'h13,      32'hAB,2'b10,2'b00,32'h3C080001});
    tv.push_back('{2'b00,2'b10,4'b0010,32'hBFC00000,32'h13,32'h0,32'hAB,1'b0,1'b0,32'h0,       1'b0,1'b0,2'd0,32'h0,       32'h0, 2'b00,2'b00,32'h3C080001});
    tv.push_back('{2'b00,2'b10,4'b0010,32'hBFC00000,32'h13,32'h0,32'hAB,1'b0,1'b0,32'h0,       1'b0,1'b0,2'd0,32'h0,       32'h0, 2'b00,2'b00,32'h3C080001});
    tv.push_back('{2'b00,2'b10,4'b0010,32'hBFC00000,32'h13,32'h0,32'hAB,1'b0,1'b1,32'h55,      1'b0,1'b0,2'd0,32'h0,       32'h0, 2'b00,2'b10,32'h55});
    tv.push_back('{2'b00,2'b00,4'b0010,32'hBFC00000,32'h13,32'h0,32'hAB,1'b0,1'b1,32'h77,      1'b0,1'b0,2'd0,32'h0,       32'h0, 2'b00,2'b00,32'h55});

`ifdef ARB_FIXED_PRIO_EN
    exp_rr = '{0, 0, 0, 0};
`else
    exp_rr = '{0, 1, 0, 1};
`endif

    // Reset state, with requests present to show they are ignored in reset.
    resetn        = 1'b0;
    bus.m_req     = 2'b11;
    bus.m_wr      = '0;
    bus.m_size    = '0;
    bus.m_addr    = {32'h2000, 32'h1000};
    bus.m_wdata   = '0;
    bus.s_addr_ok = 1'b1;
    bus.s_data_ok = 1'b1;
    bus.s_rdata   = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_s_req",     bus.s_req,     0);
    chk("rst_s_addr",    bus.s_addr,    0);
    chk("rst_m_addr_ok", bus.m_addr_ok, 0);
    chk("rst_m_data_ok", bus.m_data_ok, 0);
    chk("rst_m_rdata",   bus.m_rdata,   0);
    bus.m_req     = '0;
    bus.s_addr_ok = 1'b0;
    bus.s_data_ok = 1'b0;
    resetn        = 1'b1;

    // Table-driven cycle vectors.
    foreach (tv[r]) begin
      @(negedge clk);
      bus.m_req     = tv[r].req;
      bus.m_wr      = tv[r].wr;
      bus.m_size    = tv[r].size;
      bus.m_addr    = {tv[r].a1, tv[r].a0};
      bus.m_wdata   = {tv[r].w1, tv[r].w0};
      bus.s_addr_ok = tv[r].sao;
      bus.s_data_ok = tv[r].sdo;
      bus.s_rdata   = tv[r].srd;
      #1;
      chk("tv_s_req",     bus.s_req,     tv[r].e_sreq);
      chk("tv_s_wr",      bus.s_wr,      tv[r].e_swr);
      chk("tv_s_size",    bus.s_size,    tv[r].e_ssize);
      chk("tv_s_addr",    bus.s_addr,    tv[r].e_saddr);
      chk("tv_s_wdata",   bus.s_wdata,   tv[r].e_swdata);
      chk("tv_m_addr_ok", bus.m_addr_ok, tv[r].e_aok);
      chk("tv_m_data_ok", bus.m_data_ok, tv[r].e_dok);
      chk("tv_m_rdata",   bus.m_rdata,   tv[r].e_rdata);
    end

    // Both channels request continuously against a zero-wait slave.
    bus.m_wr    = '0;
    bus.m_size  = 4'b1010;
    bus.m_addr  = {32'h200, 32'h100};
    bus.m_wdata = '0;
    got = '{-1, -1, -1, -1};
    ndok = 0; ngrant = 0; dph = 1'b0;
    for (int c = 0; c < 60 && ndok < 4; c++) begin
      @(negedge clk);
      bus.m_req     = 2'b11;
      bus.s_addr_ok = 1'b0;
      bus.s_data_ok = 1'b0;
      bus.s_rdata   = 32'(c);
      #1;
      if (dph) bus.s_data_ok = 1'b1;
      else if (bus.s_req) bus.s_addr_ok = 1'b1;
      #1;
      if (bus.m_addr_ok != '0 && ngrant < 4) begin
        got[ngrant] = bus.m_addr_ok[1] ? 1 : 0;
        ngrant++;
      end
      if (bus.s_data_ok) begin dph = 1'b0; ndok++; end
      else if (bus.s_addr_ok) dph = 1'b1;
    end
    chk("rr_done", ndok, 4);
    for (int k = 0; k < 4; k++) chk("rr_grant", got[k], exp_rr[k]);

    // Cancel: ch0 withdraws in the address phase, ch1 is served next.
    step(2'b01, 1'b0, 1'b0, 32'h0);  chk("cx_idle_s_req", bus.s_req, 0);
    step(2'b01, 1'b0, 1'b0, 32'h0);  chk("cx_addr_s_req", bus.s_req, 1);
                                     chk("cx_addr_s_addr", bus.s_addr, 32'h100);
    step(2'b10, 1'b0, 1'b0, 32'h0);  chk("cx_drop_s_req", bus.s_req, 0);
                                     chk("cx_drop_aok", bus.m_addr_ok, 0);
    step(2'b10, 1'b0, 1'b0, 32'h0);  chk("cx_idle2_s_req", bus.s_req, 0);
                                     chk("cx_idle2_dok", bus.m_data_ok, 0);
    step(2'b10, 1'b1, 1'b0, 32'h0);  chk("cx_ch1_s_addr", bus.s_addr, 32'h200);
                                     chk("cx_ch1_aok", bus.m_addr_ok, 2'b10);
    step(2'b00, 1'b0, 1'b1, 32'h1234); chk("cx_ch1_dok", bus.m_data_ok, 2'b10);
                                     chk("cx_ch1_rdata", bus.m_rdata, 32'h1234);

    // Reset asserted while waiting for data_ok, then a clean ch0 read.
    step(2'b01, 1'b0, 1'b0, 32'h0);
    step(2'b01, 1'b1, 1'b0, 32'h0);  chk("mr_aok", bus.m_addr_ok, 2'b01);
    step(2'b00, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    resetn        = 1'b0;
    bus.s_data_ok = 1'b1;
    bus.s_rdata   = 32'hCAFE;
    #1;
    chk("mr_rst_dok",   bus.m_data_ok, 0);
    chk("mr_rst_rdata", bus.m_rdata,   0);
    chk("mr_rst_s_req", bus.s_req,     0);
    @(negedge clk);
    bus.s_data_ok = 1'b0;
    resetn        = 1'b1;
    step(2'b01, 1'b0, 1'b0, 32'h0);  chk("mr_idle_s_req", bus.s_req, 0);
    step(2'b01, 1'b0, 1'b0, 32'h0);  chk("mr_addr_s_req", bus.s_req, 1);
                                     chk("mr_addr_s_addr", bus.s_addr, 32'h100);
    step(2'b01, 1'b1, 1'b0, 32'h0);  chk("mr_aok2", bus.m_addr_ok, 2'b01);
    step(2'b00, 1'b0, 1'b1, 32'hBEEF); chk("mr_dok2", bus.m_data_ok, 2'b01);
                                     chk("mr_rdata2", bus.m_rdata, 32'hBEEF);
    step(2'b00, 1'b0, 1'b0, 32'h0);  chk("mr_hold_rdata", bus.m_rdata, 32'hBEEF);
                                     chk("mr_after_dok", bus.m_data_ok, 0);

    // Randomised traffic against the reference model.
    do_reset();
    mreq = '0; prev_aok = '0;
    for (int i = 0; i < NCH; i++) begin
      maddr[i] = '0; mwd[i] = '0; mwr[i] = 1'b0; msz[i] = '0;
    end
    ph = 0; eg = 0; lastg = NCH - 1; scnt = 0; ntx = 0; sbusy = 1'b0; mrd = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++) begin
        if (mreq[i] && prev_aok[i]) begin
          mreq[i] = 1'b0;
        end else if (!mreq[i] && $urandom_range(0, 2) == 0) begin
          mreq[i]  = 1'b1;
          maddr[i] = $urandom;
          mwd[i]   = $urandom;
          mwr[i]   = 1'($urandom_range(0, 1));
          msz[i]   = 2'($urandom_range(0, 3));
        end
        bus.m_wr[i]            = mwr[i];
        bus.m_size[2*i +: 2]   = msz[i];
        bus.m_addr[32*i +: 32] = maddr[i];
        bus.m_wdata[32*i +: 32] = mwd[i];
      end
      bus.m_req     = mreq;
      bus.s_addr_ok = 1'b0;
      bus.s_data_ok = 1'b0;
      bus.s_rdata   = $urandom;
      #1;
      if (sbusy) begin
        if (scnt == 0) bus.s_data_ok = 1'b1;
        else scnt--;
      end else if (bus.s_req && $urandom_range(0, 1) == 1) begin
        bus.s_addr_ok = 1'b1;
      end
      #1;
      chk("rnd_s_req", bus.s_req, (ph == 1) ? 1 : 0);
      if (ph == 1) begin
        chk("rnd_s_addr",  bus.s_addr,  maddr[eg]);
        chk("rnd_s_wr",    bus.s_wr,    mwr[eg]);
        chk("rnd_s_size",  bus.s_size,  msz[eg]);
        chk("rnd_s_wdata", bus.s_wdata, mwd[eg]);
      end
      chk("rnd_m_addr_ok", bus.m_addr_ok, (ph == 1 && bus.s_addr_ok) ? (2'b01 << eg) : 2'b00);
      chk("rnd_m_data_ok", bus.m_data_ok, (ph == 2 && bus.s_data_ok) ? (2'b01 << eg) : 2'b00);
      if (ph == 2 && bus.s_data_ok) mrd = bus.s_rdata;
      chk("rnd_m_rdata", bus.m_rdata, mrd);
      prev_aok = bus.m_addr_ok;
      if (bus.s_addr_ok) begin
        sbusy = 1'b1;
        scnt  = $urandom_range(0, 3);
      end else if (bus.s_data_ok) begin
        sbusy = 1'b0;
      end
      case (ph)
        0: if (mreq != '0) begin eg = pick(lastg, mreq); ph = 1; end
        1: if (bus.s_addr_ok) begin lastg = eg; ph = 2; end
        default: if (bus.s_data_ok) begin ph = 0; ntx++; end
      endcase
    end
    chk("rnd_enough_txns", (ntx >= 50) ? 1 : 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
